history_rmw: RTL and testbench

HISTORY_RMW -- requirements
Module: history_rmw

---
 rtl/trail_pkg.sv | 15 +
 rtl/history_rmw_fwd_table.sv | 62 ++++++
 rtl/history_rmw.sv | 142 ++++++++++++++
 tb/tb_history_rmw.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trail_pkg.sv
// Shared constants and FSM state type for the history read-modify-write path.
package trail_pkg;

  localparam int unsigned FRAME_W         = 320;
  localparam int unsigned FRAME_H         = 240;
  localparam int unsigned COLOR_DEPTH_DEF = 8;
  localparam int unsigned FWD_CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } trail_state_e;

endpackage

// File: rtl/history_rmw_fwd_table.sv
// Write-forwarding table: the live write plus the previous DEPTH-1 writes, newest match wins.
// Only built when HISTORY_FWD_EN is defined.
`ifdef HISTORY_FWD_EN
module fwd_table #(
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned COLOR_DEPTH = 8,
  parameter int unsigned DEPTH       = 3
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   wr_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [COLOR_DEPTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic                   hit_c,
  output logic [COLOR_DEPTH-1:0] data_c
);

  localparam int unsigned REGS = DEPTH - 1;

  logic [REGS-1:0]        ent_v;
  logic [ADDR_WIDTH-1:0]  ent_a [REGS];
  logic [COLOR_DEPTH-1:0] ent_d [REGS];

  // Shift on every write; entry 0 is the most recent registered write.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ent_v <= '0;
      for (int i = 0; i < int'(REGS); i++) begin
        ent_a[i] <= '0;
        ent_d[i] <= '0;
      end
    end else if (wr_en) begin
      ent_v[0] <= 1'b1;
      ent_a[0] <= wr_addr;
      ent_d[0] <= wr_data;
      for (int i = 1; i < int'(REGS); i++) begin
        ent_v[i] <= ent_v[i-1];
        ent_a[i] <= ent_a[i-1];
        ent_d[i] <= ent_d[i-1];
      end
    end
  end

  // Oldest first so later (newer) matches override; the live write is newest of all.
  always_comb begin
    hit_c  = 1'b0;
    data_c = '0;
    for (int i = int'(REGS) - 1; i >= 0; i--) begin
      if (ent_v[i] && (ent_a[i] == rd_addr)) begin
        hit_c  = 1'b1;
        data_c = ent_d[i];
      end
    end
    if (wr_en && (wr_addr == rd_addr)) begin
      hit_c  = 1'b1;
      data_c = wr_data;
    end
  end

endmodule
`endif

// File: rtl/history_rmw.sv
// History frame-buffer read-modify-write front end for the IIR trail filter.
// Optional write forwarding for read-after-write hazards: define HISTORY_FWD_EN.
module history_rmw
  import trail_pkg::*;
#(
  parameter int unsigned COLOR_DEPTH = COLOR_DEPTH_DEF,
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   valid_in,
  input  logic [ADDR_WIDTH-1:0]  addr_in,
  input  logic [COLOR_DEPTH-1:0] camera_in,
  input  logic                   frame_done_in,
  output logic [ADDR_WIDTH-1:0]  rd_addr_out,
  input  logic [COLOR_DEPTH-1:0] rd_data_in,
  output logic                   valid_out,
  output logic [COLOR_DEPTH-1:0] history_out,
  output logic [COLOR_DEPTH-1:0] camera_out,
  input  logic                   update_valid_in,
  input  logic [COLOR_DEPTH-1:0] update_in,
  output logic                   wr_en_out,
  output logic [ADDR_WIDTH-1:0]  wr_addr_out,
  output logic [COLOR_DEPTH-1:0] wr_data_out,
  output logic                   primed_out,
  output logic [FWD_CNT_W-1:0]   fwd_count_out
);

  localparam int unsigned LAST = RD_LATENCY - 1;

  trail_state_e state, state_nxt;
  logic         run_mode;

  logic [RD_LATENCY-1:0]  v_pipe;
  logic [RD_LATENCY-1:0]  run_pipe;
  logic [ADDR_WIDTH-1:0]  a_pipe [RD_LATENCY];
  logic [COLOR_DEPTH-1:0] c_pipe [RD_LATENCY];
  logic                   wb_valid;
  logic [ADDR_WIDTH-1:0]  wb_addr;
  logic [COLOR_DEPTH-1:0] run_data;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (valid_in)      state_nxt = ST_PRIME;
      ST_PRIME: if (frame_done_in) state_nxt = ST_RUN;
      ST_RUN:                      state_nxt = ST_RUN;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    run_mode   = 1'b0;
    primed_out = 1'b0;
    if (state == ST_RUN) begin
      run_mode   = 1'b1;
      primed_out = 1'b1;
    end
  end

  // Mode is latched per pixel at issue, so a frame boundary only affects later pixels.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v_pipe   <= '0;
      run_pipe <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
        a_pipe[i] <= '0;
        c_pipe[i] <= '0;
      end
    end else begin
      v_pipe[0]   <= valid_in;
      run_pipe[0] <= valid_in & run_mode;
      a_pipe[0]   <= valid_in ? addr_in : '0;
      c_pipe[0]   <= valid_in ? camera_in : '0;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        v_pipe[i]   <= v_pipe[i-1];
        run_pipe[i] <= run_pipe[i-1];
        a_pipe[i]   <= a_pipe[i-1];
        c_pipe[i]   <= c_pipe[i-1];
      end
      wb_valid <= v_pipe[LAST];
      wb_addr  <= a_pipe[LAST];
    end
  end

  assign rd_addr_out = addr_in;
  assign valid_out   = v_pipe[LAST];
  assign camera_out  = c_pipe[LAST];

  // Write-back pairs the IIR result with the pixel that left the pipe last cycle.
  assign wr_en_out   = update_valid_in & wb_valid & ~rst_in;
  assign wr_addr_out = wr_en_out ? wb_addr : '0;
  assign wr_data_out = wr_en_out ? update_in : '0;

`ifdef HISTORY_FWD_EN
  logic                   fwd_hit_c;
  logic [COLOR_DEPTH-1:0] fwd_data_c;
  logic [FWD_CNT_W-1:0]   fwd_cnt;

  fwd_table #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .COLOR_DEPTH (COLOR_DEPTH),
    .DEPTH       (RD_LATENCY + 1)
  ) u_fwd_table (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .wr_en   (wr_en_out),
    .wr_addr (wr_addr_out),
    .wr_data (wr_data_out),
    .rd_addr (a_pipe[LAST]),
    .hit_c   (fwd_hit_c),
    .data_c  (fwd_data_c)
  );

  assign run_data = fwd_hit_c ? fwd_data_c : rd_data_in;

  always_ff @(posedge clk_in) begin
    if (rst_in || frame_done_in) begin
      fwd_cnt <= '0;
    end else if (valid_out && run_pipe[LAST] && fwd_hit_c && (fwd_cnt != '1)) begin
      fwd_cnt <= fwd_cnt + FWD_CNT_W'(1);
    end
  end

  assign fwd_count_out = fwd_cnt;
`else
  assign run_data      = rd_data_in;
  assign fwd_count_out = '0;
`endif

  // Before the first full frame the camera seeds the history directly.
  assign history_out = !valid_out ? '0 : (run_pipe[LAST] ? run_data : camera_out);

endmodule

// File: tb/tb_history_rmw.sv
// Randomized self-checking bench for history_rmw with a BRAM model and a frame-level reference.
module tb_history_rmw;

  localparam int unsigned CD = 8;
  localparam int unsigned AW = 17;
  localparam int unsigned L  = 2;
  localparam int unsigned NPIX = 320 * 240;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          valid_in = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [CD-1:0] camera_in = '0;
  logic          frame_done_in = 1'b0;
  logic [AW-1:0] rd_addr_out;
  logic [CD-1:0] rd_data_in = '0;
  logic          valid_out;
  logic [CD-1:0] history_out;
  logic [CD-1:0] camera_out;
  logic          update_valid_in = 1'b0;
  logic [CD-1:0] update_in = '0;
  logic          wr_en_out;
  logic [AW-1:0] wr_addr_out;
  logic [CD-1:0] wr_data_out;
  logic          primed_out;
  logic [15:0]   fwd_count_out;

  always #5 clk_in = ~clk_in;

  history_rmw #(.COLOR_DEPTH(CD), .ADDR_WIDTH(AW), .RD_LATENCY(L)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .addr_in(addr_in),
    .camera_in(camera_in), .frame_done_in(frame_done_in), .rd_addr_out(rd_addr_out),
    .rd_data_in(rd_data_in), .valid_out(valid_out), .history_out(history_out),
    .camera_out(camera_out), .update_valid_in(update_valid_in), .update_in(update_in),
    .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .primed_out(primed_out), .fwd_count_out(fwd_count_out)
  );

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [CD-1:0] cam;
    bit            run;
    logic [CD-1:0] old;
  } pix_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [CD-1:0] mem    [0:(1<<AW)-1];
  logic [CD-1:0] refmem [0:(1<<AW)-1];
  logic [CD-1:0] rdpipe [L];
  pix_t          iq [$];
  logic [AW-1:0] win [$];
  pix_t          prev_pix;
  bit            prev_ok = 0;
  int unsigned   cnt = 0;
  int            m_state = 0;  // 0 idle, 1 prime, 2 run
  bit            upd_fixed = 0;
  logic [CD-1:0] upd_val = '0;
  logic [AW-1:0] s_rd_addr = '0;
  bit            s_we = 0;
  logic [AW-1:0] s_wa = '0;
  logic [CD-1:0] s_wd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: BRAM model, drive inputs, then predict and compare this cycle's outputs.
  task automatic step(input bit v, input logic [AW-1:0] a, input logic [CD-1:0] c,
                      input bit fd, input bit rst);
    pix_t          cur;
    bit            due;
    bit            w_ok;
    bit            hit;
    logic [AW-1:0] w_a;
    logic [CD-1:0] w_d;
    logic [CD-1:0] exp_h;
    @(posedge clk_in);
    cyc++;
    for (int i = int'(L) - 1; i > 0; i--) rdpipe[i] = rdpipe[i-1];
    rdpipe[0] = mem[s_rd_addr];
    if (s_we) mem[s_wa] = s_wd;
    #1;
    valid_in        = v;
    addr_in         = a;
    camera_in       = c;
    frame_done_in   = fd;
    rst_in          = rst;
    update_valid_in = prev_ok;
    update_in       = upd_fixed ? upd_val : CD'($urandom);
    if (upd_fixed && prev_ok) upd_val = upd_val + CD'(1);
    rd_data_in      = rdpipe[L-1];
    #1;
    s_rd_addr = rd_addr_out;
    s_we      = wr_en_out;
    s_wa      = wr_addr_out;
    s_wd      = wr_data_out;
    check("rd_addr", 32'(rd_addr_out), 32'(a));
    if (rst) begin
      check("wr_en_in_reset", 32'(wr_en_out), 32'd0);
      iq.delete();
      win.delete();
      prev_ok = 0;
      m_state = 0;
      cnt     = 0;
      return;
    end
    w_ok = prev_ok;
    w_a  = prev_pix.addr;
    w_d  = update_in;
    if (v) iq.push_back('{cyc + int'(L), a, c, (m_state == 2), refmem[a]});
    if (w_ok) begin
      refmem[w_a] = w_d;
      win.push_back(w_a);
      if (win.size() > int'(L) + 1) void'(win.pop_front());
    end
    cur   = '{0, '0, '0, 0, '0};
    due   = (iq.size() > 0) && (iq[0].due == cyc);
    hit   = 0;
    exp_h = '0;
    if (due) begin
      cur = iq.pop_front();
      if (!cur.run) begin
        exp_h = cur.cam;
      end else begin
`ifdef HISTORY_FWD_EN
        exp_h = refmem[cur.addr];
        foreach (win[i]) if (win[i] == cur.addr) hit = 1;
`else
        exp_h = cur.old;
`endif
      end
    end
    check("valid_out", 32'(valid_out), 32'(due));
    check("camera_out", 32'(camera_out), 32'(cur.cam));
    check("history_out", 32'(history_out), 32'(exp_h));
    check("wr_en", 32'(wr_en_out), 32'(w_ok));
    check("wr_addr", 32'(wr_addr_out), w_ok ? 32'(w_a) : 32'd0);
    check("wr_data", 32'(wr_data_out), w_ok ? 32'(w_d) : 32'd0);
    check("primed", 32'(primed_out), 32'(m_state == 2));
    check("fwd_count", 32'(fwd_count_out), cnt);
    if (fd) cnt = 0;
    else if (hit && cnt < 32'hFFFF) cnt++;
    prev_ok  = due;
    prev_pix = cur;
    if (m_state == 0 && v) m_state = 1;
    else if (m_state == 1 && fd) m_state = 2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0);
  endtask

  initial begin
    int unsigned raster;
    int          nrand;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = CD'($urandom);
      refmem[i] = mem[i];
    end
    for (int i = 0; i < int'(L); i++) rdpipe[i] = '0;
    prev_pix = '{0, '0, '0, 0, '0};

    step(0, '0, '0, 0, 1);
    step(0, '0, '0, 0, 1);
    idle(1);
    check("reset_hist", 32'(history_out), 32'd0);
    check("reset_primed", 32'(primed_out), 32'd0);

    // Seeding pixel in PRIME passes the camera straight through.
    step(1, AW'(5), 8'h3C, 0, 0);
    idle(2);
    check("seed_valid", 32'(valid_out), 32'd1);
    check("seed_hist", 32'(history_out), 32'h3C);
    idle(1);
    check("seed_wr_en", 32'(wr_en_out), 32'd1);
    check("seed_wr_addr", 32'(wr_addr_out), 32'd5);

    // First RUN pixel reads history from BRAM.
    mem[7]    = 8'h10;
    refmem[7] = 8'h10;
    step(0, '0, '0, 1, 0);
    step(1, AW'(7), 8'h99, 0, 0);
    idle(2);
    check("run_hist", 32'(history_out), 32'h10);
    check("run_primed", 32'(primed_out), 32'd1);
    idle(1);

    // Back-to-back hazard on one address.
    upd_fixed = 1;
    upd_val   = 8'hA0;
    for (int i = 0; i < 3; i++) step(1, AW'(9), CD'($urandom), 0, 0);
    idle(1);
`ifdef HISTORY_FWD_EN
    check("haz_hist2", 32'(history_out), 32'hA0);
`else
    check("haz_hist2", 32'(history_out), 32'(rd_data_in));
`endif
    idle(1);
`ifdef HISTORY_FWD_EN
    check("haz_hist3", 32'(history_out), 32'hA1);
`else
    check("haz_hist3", 32'(history_out), 32'(rd_data_in));
`endif
    idle(1);
`ifdef HISTORY_FWD_EN
    check("haz_count", 32'(fwd_count_out), 32'd2);
`else
    check("haz_count", 32'(fwd_count_out), 32'd0);
`endif
    upd_fixed = 0;
    idle(1);

    // Reset with two pixels in flight.
    step(1, AW'(11), 8'h11, 0, 0);
    step(1, AW'(12), 8'h12, 0, 0);
    step(0, '0, '0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("flush_wr_en", 32'(wr_en_out), 32'd0);
    end
    check("flush_primed", 32'(primed_out), 32'd0);
    check("flush_valid", 32'(valid_out), 32'd0);

    step(1, AW'(20), 8'h20, 0, 0);
    idle(3);
    step(0, '0, '0, 1, 0);
    idle(1);

`ifdef HISTORY_FWD_EN
    // Saturate the forward counter, then clear it with a frame boundary.
    for (int i = 0; i < 65600; i++) step(1, AW'(100), CD'($urandom), 0, 0);
    idle(3);
    check("sat_count", 32'(fwd_count_out), 32'hFFFF);
    step(0, '0, '0, 1, 0);
    check("sat_hold_in_fd", 32'(fwd_count_out), 32'hFFFF);
    idle(1);
    check("sat_clear", 32'(fwd_count_out), 32'd0);
    nrand = 12000;
`else
    nrand = 20000;
`endif

    // Raster frame traffic with random gaps, hazards, wide addresses and rare resets.
    raster = 0;
    for (int k = 0; k < nrand; k++) begin
      bit            v;
      int unsigned   r;
      logic [AW-1:0] a;
      v = ($urandom_range(0, 99) < 65);
      r = $urandom_range(0, 9);
      if (r < 3) a = AW'($urandom_range(0, 7));
      else if (r == 3) a = AW'($urandom);
      else begin
        a = AW'(raster);
        if (v) raster = (raster + 1) % NPIX;
      end
      step(v, a, CD'($urandom), ($urandom_range(0, 599) == 0), ($urandom_range(0, 4999) == 0));
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
